// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and gates decoder strobes.
// Optional execute/skip statistics counters are built when COND_LOGIC_STATS_EN is defined.
module cond_logic #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic       stall,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  input  logic       flag_load,
  input  logic [3:0] flag_load_val,
  output logic       cond_ex,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags
`ifdef COND_LOGIC_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] exec_count,
  output logic [15:0] skip_count
`endif
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  logic [3:0] flags_q, flags_d;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Decode works only on the registered flags; there is no same-cycle forwarding from alu_flags.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cond_pass = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = !flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = !flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = !flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = !flag_v;
      COND_HI: cond_pass = flag_c && !flag_z;
      COND_LS: cond_pass = !flag_c || flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = !flag_z && (flag_n == flag_v);
      COND_LE: cond_pass = flag_z || (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cond_ex   = instr_valid & cond_pass;
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex & !no_write;
  assign mem_write = mem_w & cond_ex;
  assign flags     = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (!stall) begin
      if (flag_load) begin
        flags_d = flag_load_val;
      end else if (cond_ex) begin
        if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) flags_q <= RESET_FLAGS;
    else        flags_q <= flags_d;
  end

`ifdef COND_LOGIC_STATS_EN
  logic [15:0] exec_q, exec_d;
  logic [15:0] skip_q, skip_d;

  // Stall freezes the counters like all other state; clear beats increment; both saturate.
  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (!stall) begin
      if (stat_clr) begin
        exec_d = '0;
        skip_d = '0;
      end else if (instr_valid) begin
        if (cond_ex) begin
          if (exec_q != 16'hFFFF) exec_d = exec_q + 16'd1;
        end else begin
          if (skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign exec_count = exec_q;
  assign skip_count = skip_q;
`endif

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage that sits directly downstream of the instruction decoder in the ARM single-cycle datapath.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the current flags.
- Gates the decoder's PCS/RegW/MemW strobes so that a failed condition turns the instruction into a no-op.
- Updates the flags from the ALU under the decoder's FlagW control.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset ({N,Z,C,V}, N in bit 3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  decoded instruction present this cycle.
- stall  input  1  pipeline hold; freezes all state this cycle.
- cond  input  4  instruction bits [31:28].
- alu_flags  input  4  {N,Z,C,V} produced by the ALU for the current instruction.
- flag_w  input  2  from decoder: bit1 enables N,Z write; bit0 enables C,V write.
- pcs  input  1  from decoder: instruction writes PC (branch or Rd=15).
- reg_w  input  1  from decoder: register write request.
- mem_w  input  1  from decoder: memory write request.
- no_write  input  1  suppress register write (CMP/CMN/TST/TEQ).
- flag_load  input  1  direct flag load (MSR-style).
- flag_load_val  input  4  NZCV value for flag_load.
- cond_ex  output  1  condition passed and instr_valid.
- pc_src  output  1  gated pcs.
- reg_write  output  1  gated reg_w.
- mem_write  output  1  gated mem_w.
- flags  output  4  current registered NZCV.

Behaviour:
- Reset (rst_n=0, asynchronous): flags=RESET_FLAGS. All other outputs are combinational and follow from the reset flags.
- Condition decode is combinational on the registered flags, never on alu_flags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: reserved, treated as never (0).
- cond_ex = instr_valid & cond_pass.
- Output gating, all zero-latency combinational:
  - pc_src = pcs & cond_ex.
  - reg_write = reg_w & cond_ex & !no_write.
  - mem_write = mem_w & cond_ex.
- stall does not gate the combinational outputs. The downstream stage owns the hold.
- Flag update, at the rising clk edge when stall=0, in priority order:
  1. flag_load=1: flags <= flag_load_val, regardless of instr_valid, cond_ex or flag_w.
  2. Else if cond_ex=1:
     - flag_w[1]: N,Z <= alu_flags[3:2].
     - flag_w[0]: C,V <= alu_flags[1:0].
     - Halves not enabled hold their value.
  3. Else: flags hold.
- stall=1: flags hold, flag_load included.
- Back-to-back dependency: an instruction sees flags written by the previous non-stalled cycle, one-cycle latency. Same-cycle forwarding is not provided.
- X-safety: with instr_valid=0, every gated output is 0 whatever the other inputs are.

Optional Feature:
- Macro: COND_LOGIC_STATS_EN.
- When defined, the following ports are added:
  - stat_clr, input, 1.
  - exec_count, output, 16.
  - skip_count, output, 16.
- Counter behaviour:
  - Each non-stalled cycle with instr_valid=1 increments exec_count if cond_ex=1, otherwise skip_count.
  - Counters saturate at 16'hFFFF.
  - stat_clr=1 zeroes both synchronously and has priority over increment.
  - Reset value of both is 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low mid-cycle with flags=4'b1111 -> flags=4'b0000 immediately (asynchronous). Then cond=0000 gives cond_ex=0; cond=1110 with instr_valid=1 gives cond_ex=1.
- Flag write halves: flags=0000, cond=1110, flag_w=2'b10, alu_flags=4'b1111 -> next edge flags=4'b1100. Then flag_w=2'b01, alu_flags=4'b0011 -> flags=4'b1111.
- Exhaustive condition sweep: for all 16 flag values × 16 cond codes, compare cond_ex against the reference table. Cond 1111 always yields 0.
- Failed condition: flags=4'b0000, cond=0000 (EQ), reg_w=mem_w=pcs=1, flag_w=2'b11, alu_flags=4'b0100 -> reg_write=mem_write=pc_src=0 and flags stay 4'b0000 after the edge.
- Priority and stall:
  - flag_load=1 with flag_load_val=4'b1010, cond_ex=1, flag_w=11, alu_flags=0101 -> flags=4'b1010.
  - Same inputs with stall=1 -> flags unchanged.
- Stats (COND_LOGIC_STATS_EN): 3 passing and 2 failing valid instructions plus 1 stalled instruction -> exec_count=3, skip_count=2. Forcing exec_count to 16'hFFFF and executing once more leaves it at 16'hFFFF. stat_clr -> both 0 on the next edge.
